// File: rtl/dsd_cic_pkg.sv
// rtl/dsd_cic_pkg.sv - shared constants and sizing helpers for the DSD CIC decimator
package dsd_cic_pkg;

    localparam int CIC_ORDER     = 4;
    localparam int WARMUP_FRAMES = CIC_ORDER;

    // Bit growth is ORDER*log2(R); the +2 covers the +/-1 input sign and one guard bit.
    function automatic int cic_width(input int ratio);
        return CIC_ORDER * $clog2(ratio) + 2;
    endfunction

    function automatic int out_shift(input int cic_w, input int pcm_w);
        return cic_w - pcm_w - 1;
    endfunction

    function automatic logic signed [63:0] sat_hi(input int pcm_w);
        return (64'sd1 <<< (pcm_w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_lo(input int pcm_w);
        return -(64'sd1 <<< (pcm_w - 1));
    endfunction

endpackage

// File: rtl/dsd_cic_comb.sv
// rtl/dsd_cic_comb.sv - one CIC comb stage: y = x - x_prev, updated only on its enable
module dsd_cic_comb #(
    parameter int W = 26
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] x_i,
    output logic [W-1:0] y_o
);
    logic [W-1:0] y_q;
    logic [W-1:0] x_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            y_q      <= '0;
            x_prev_q <= '0;
        end else if (en_i) begin
            y_q      <= x_i - x_prev_q;
            x_prev_q <= x_i;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/dsd_cic_decimator.sv
// rtl/dsd_cic_decimator.sv - 4th-order CIC decimator, 1-bit DSD stream to saturated signed PCM
module dsd_cic_decimator
    import dsd_cic_pkg::*;
#(
    parameter int PCM_Bit_Length   = 24,
    parameter int Decimation_Ratio = 64
) (
    input  logic                             CLK_I,
    input  logic                             NRST_I,
    input  logic                             DSD_I,
    input  logic                             DSD_EN_I,
    output logic signed [PCM_Bit_Length-1:0] DATA_O,
    output logic                             VALID_O
);
    localparam int CW    = cic_width(Decimation_Ratio);
    localparam int SHIFT = out_shift(CW, PCM_Bit_Length);
    localparam int DW    = $clog2(Decimation_Ratio);
    localparam logic signed [63:0] SAT_HI = sat_hi(PCM_Bit_Length);
    localparam logic signed [63:0] SAT_LO = sat_lo(PCM_Bit_Length);

    // R >= 8 guarantees the 4-cycle comb pipeline drains before the next capture.
    if (Decimation_Ratio < 8 || Decimation_Ratio > 256 ||
        (Decimation_Ratio & (Decimation_Ratio - 1)) != 0) begin : g_bad_ratio
        $error("Decimation_Ratio must be a power of two in 8..256");
    end

    logic [CW-1:0]                    integ_q [CIC_ORDER];
    logic [CW-1:0]                    integ_d [CIC_ORDER];
    logic [DW-1:0]                    dec_q, dec_d;
    logic [CIC_ORDER-1:0]             v_q, v_d;
    logic [2:0]                       warm_q, warm_d;
    logic signed [PCM_Bit_Length-1:0] data_q, data_d;
    logic                             valid_q, valid_d;
    logic                             capture;
    logic [CIC_ORDER-1:0][CW-1:0]     comb_x, comb_y;
    logic signed [CW-1:0]             comb_shr;
    logic signed [63:0]               comb_wide;

    // Integrators ripple within one cycle so the capture sees the freshly updated 4th stage.
    always_comb begin
        integ_d[0] = integ_q[0] + (DSD_I ? {{(CW-1){1'b0}}, 1'b1} : {CW{1'b1}});
        for (int i = 1; i < CIC_ORDER; i++) begin
            integ_d[i] = integ_q[i] + integ_d[i-1];
        end
    end

    assign capture = DSD_EN_I & (&dec_q);
    assign dec_d   = DSD_EN_I ? dec_q + {{(DW-1){1'b0}}, 1'b1} : dec_q;
    assign v_d     = {v_q[CIC_ORDER-2:0], capture};
    assign comb_x  = {comb_y[CIC_ORDER-2:0], integ_d[CIC_ORDER-1]};

    for (genvar g = 0; g < CIC_ORDER; g++) begin : g_comb
        dsd_cic_comb #(.W(CW)) u_comb (
            .clk_i  (CLK_I),
            .rst_ni (NRST_I),
            .en_i   (v_d[g]),
            .x_i    (comb_x[g]),
            .y_o    (comb_y[g])
        );
    end

    assign comb_shr  = $signed(comb_y[CIC_ORDER-1]) >>> SHIFT;
    assign comb_wide = {{(64-CW){comb_shr[CW-1]}}, comb_shr};

    always_comb begin
        warm_d  = warm_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (v_q[CIC_ORDER-1]) begin
            if (warm_q < 3'(WARMUP_FRAMES)) begin
                warm_d = warm_q + 3'd1;
            end else begin
                valid_d = 1'b1;
                if (comb_wide > SAT_HI) begin
                    data_d = SAT_HI[PCM_Bit_Length-1:0];
                end else if (comb_wide < SAT_LO) begin
                    data_d = SAT_LO[PCM_Bit_Length-1:0];
                end else begin
                    data_d = comb_wide[PCM_Bit_Length-1:0];
                end
            end
        end
    end

    always_ff @(posedge CLK_I or negedge NRST_I) begin
        if (!NRST_I) begin
            for (int i = 0; i < CIC_ORDER; i++) begin
                integ_q[i] <= '0;
            end
            dec_q   <= '0;
            v_q     <= '0;
            warm_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (DSD_EN_I) begin
                for (int i = 0; i < CIC_ORDER; i++) begin
                    integ_q[i] <= integ_d[i];
                end
            end
            dec_q   <= dec_d;
            v_q     <= v_d;
            warm_q  <= warm_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign DATA_O  = data_q;
    assign VALID_O = valid_q;

endmodule

// File: tb/tb_dsd_cic_decimator.sv
// tb/tb_dsd_cic_decimator.sv - scoreboard bench for dsd_cic_decimator at default parameters
module tb_dsd_cic_decimator;
    localparam int PCM_W = 24;
    localparam int R     = 64;
    localparam int NTAP  = 4 * (R - 1) + 1;
    localparam int PMAX  = 8388607;
    localparam int PMIN  = -8388608;

    typedef struct {
        int val;
        int at;
    } exp_t;

    logic                    CLK_I    = 1'b0;
    logic                    NRST_I   = 1'b0;
    logic                    DSD_I    = 1'b0;
    logic                    DSD_EN_I = 1'b0;
    logic signed [PCM_W-1:0] DATA_O;
    logic                    VALID_O;

    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    int     rx_cnt = 0;
    int     last_data = 0;
    int     samp   = 0;
    int     frames = 0;
    int     exp_const = 0;
    bit     use_model = 1'b0;
    bit     acc_mean  = 1'b0;
    longint mean_sum  = 0;
    int     mean_n    = 0;
    exp_t   exp_q[$];
    int     hist[$];
    int     h[NTAP];

    dsd_cic_decimator #(
        .PCM_Bit_Length   (PCM_W),
        .Decimation_Ratio (R)
    ) dut (
        .CLK_I    (CLK_I),
        .NRST_I   (NRST_I),
        .DSD_I    (DSD_I),
        .DSD_EN_I (DSD_EN_I),
        .DATA_O   (DATA_O),
        .VALID_O  (VALID_O)
    );

    always #5 CLK_I = ~CLK_I;
    always @(posedge CLK_I) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Direct FIR form of the CIC: four cascaded 64-tap boxcars, then >>>1 and clamp.
    function automatic int model_out();
        longint acc = 0;
        for (int m = 0; m < NTAP; m++) begin
            acc += longint'(h[m]) * longint'(hist[hist.size() - 1 - m]);
        end
        acc = acc >>> 1;
        if (acc > PMAX) acc = PMAX;
        if (acc < PMIN) acc = PMIN;
        return int'(acc);
    endfunction

    task automatic drive(input bit en, input bit d);
        exp_t e;
        @(negedge CLK_I);
        DSD_EN_I = en;
        DSD_I    = d;
        if (en) begin
            hist.push_back(d ? 1 : -1);
            if (hist.size() > NTAP) void'(hist.pop_front());
            if (samp == R - 1) begin
                samp = 0;
                frames++;
                if (frames > 4) begin
                    e.val = use_model ? model_out() : exp_const;
                    e.at  = cyc + 5;
                    exp_q.push_back(e);
                end
            end else begin
                samp++;
            end
        end
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge CLK_I);
        NRST_I    = 1'b0;
        DSD_EN_I  = 1'b0;
        DSD_I     = 1'b0;
        last_data = 0;
        samp      = 0;
        frames    = 0;
        exp_q.delete();
        hist.delete();
        #1;
        check("reset_valid", VALID_O, 0);
        check("reset_data", DATA_O, 0);
        repeat (ncyc) @(negedge CLK_I);
        NRST_I = 1'b1;
    endtask

    task automatic drain_and_count(input string name, input int want);
        repeat (10) drive(1'b0, 1'b0);
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_count"}, rx_cnt, want);
        rx_cnt = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK_I);
            if (NRST_I) begin
                if (VALID_O) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("data", DATA_O, e.val);
                        check("valid_cycle", cyc, e.at);
                        last_data = e.val;
                        rx_cnt++;
                        if (acc_mean) begin
                            mean_sum += longint'(DATA_O);
                            mean_n++;
                        end
                    end
                end else begin
                    check("data_hold", DATA_O, last_data);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        int t[NTAP];
        for (int i = 0; i < NTAP; i++) h[i] = (i < R) ? 1 : 0;
        repeat (3) begin
            for (int n = 0; n < NTAP; n++) begin
                t[n] = 0;
                for (int k = 0; k < R; k++) if (n - k >= 0) t[n] += h[n - k];
            end
            h = t;
        end

        // All ones: comb result is 2^24, >>>1 gives 2^23, clamped to 8388607.
        do_reset(3);
        use_model = 1'b0;
        exp_const = PMAX;
        repeat (7 * R) drive(1'b1, 1'b1);
        drain_and_count("ones", 3);

        do_reset(2);
        exp_const = PMIN;
        repeat (7 * R) drive(1'b1, 1'b0);
        drain_and_count("zeros", 3);

        do_reset(2);
        exp_const = 0;
        for (int i = 0; i < 7 * R; i++) drive(1'b1, (i % 2) == 0);
        drain_and_count("alternating", 3);

        do_reset(2);
        exp_const = PMAX;
        repeat (6 * R) begin
            drive(1'b1, 1'b1);
            drive(1'b0, 1'b1);
            drive(1'b0, 1'b1);
        end
        drain_and_count("sparse_en", 2);

        // Reset at sample 40 of frame 6; the new stream needs 5 whole frames again.
        do_reset(2);
        repeat (5 * R + 40) drive(1'b1, 1'b1);
        check("pre_reset_count", rx_cnt, 1);
        rx_cnt = 0;
        do_reset(2);
        repeat (5 * R - 1) drive(1'b1, 1'b1);
        repeat (8) drive(1'b0, 1'b1);
        check("no_early_valid", rx_cnt, 0);
        drive(1'b1, 1'b1);
        drain_and_count("after_reset", 1);

        // Reset while a result is inside the comb pipeline.
        do_reset(2);
        repeat (5 * R) drive(1'b1, 1'b1);
        do_reset(2);
        drain_and_count("inflight_reset", 0);

        do_reset(2);
        use_model = 1'b1;
        acc_mean  = 1'b1;
        repeat (24 * R) drive(1'b1, $urandom_range(3, 0) != 0);
        drain_and_count("random75", 20);
        acc_mean = 1'b0;
        check("mean_in_range",
              (mean_n > 0 && mean_sum / mean_n > 3145728 && mean_sum / mean_n < 5242880), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
